// File: rtl/fifo_uart_pkg.sv
// ============================================================================
// fifo_uart_pkg : shared constants and FSM encoding for the FIFO-to-UART reader
// Revision      : 1.0
// ============================================================================
`default_nettype none

package fifo_uart_pkg;

    localparam int DATA_W    = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_LATCH  = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_PARITY = 3'd5,
        S_STOP   = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// uart_baud_tick : free-running bit-period counter, restartable with clr
// Revision       : 1.0
// ============================================================================
`default_nettype none

module uart_baud_tick #(
    parameter int BAUD_DIV = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick,
    output logic tick_pre
);

    localparam int            CW     = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] c_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] c_PRE  = CW'(BAUD_DIV - 2);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr || (r_cnt == c_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // tick_pre lets the parent register an output that lines up with tick
    assign tick     = (r_cnt == c_LAST);
    assign tick_pre = (r_cnt == c_PRE) && !clr;

endmodule

`default_nettype wire

// File: rtl/fifo_uart_reader.sv
// ============================================================================
// fifo_uart_reader : pops bytes from a synchronous FIFO and sends them as UART
//                    frames (8N1; even parity added when UART_TX_PARITY_EN)
// Revision         : 1.0
// ============================================================================
`default_nettype none

module fifo_uart_reader
    import fifo_uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int BAUD_DIV = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       empty_sig,
    input  logic [7:0] FIFO_read_data,
    output logic       read_req,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int             c_BW        = $clog2(DATA_W);
    localparam logic [c_BW-1:0] c_DATA_LAST = c_BW'(DATA_W - 1);
    localparam logic [c_BW-1:0] c_STOP_LAST = c_BW'(STOP_BITS - 1);

    state_t            r_state;
    state_t            w_next;
    logic [c_BW-1:0]   r_bit_idx;
    logic [c_BW-1:0]   w_bit_next;
    logic [DATA_W-1:0] r_shift;
    logic              r_read_req;
    logic              r_tx;
    logic              r_busy;
    logic              r_tx_done;
    logic              w_clr;
    logic              w_tick;
    logic              w_tick_pre;
    logic              w_tx_next;

    uart_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_clr),
        .tick     (w_tick),
        .tick_pre (w_tick_pre)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_bit_next = r_bit_idx;
        w_clr      = 1'b0;
        case (r_state)
            S_IDLE:  if (!empty_sig) w_next = S_REQ;
            S_REQ:   w_next = S_LATCH;
            S_LATCH: begin
                w_next = S_START;
                w_clr  = 1'b1;
            end
            S_START: if (w_tick) begin
                w_next     = S_DATA;
                w_bit_next = '0;
            end
            S_DATA: if (w_tick) begin
                if (r_bit_idx == c_DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                    w_next = S_PARITY;
`else
                    w_next = S_STOP;
`endif
                    w_bit_next = '0;
                end else begin
                    w_bit_next = r_bit_idx + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (w_tick) begin
                w_next     = S_STOP;
                w_bit_next = '0;
            end
`endif
            S_STOP: if (w_tick) begin
                if (r_bit_idx == c_STOP_LAST) begin
                    w_next = S_IDLE;
                end else begin
                    w_bit_next = r_bit_idx + 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it
        case (w_next)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = r_shift[w_bit_next];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_next = ^r_shift;
`endif
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_read_req <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            r_bit_idx <= w_bit_next;
            if (r_state == S_LATCH) begin
                r_shift <= FIFO_read_data;
            end
            r_read_req <= (w_next == S_REQ);
            r_tx       <= w_tx_next;
            r_busy     <= (w_next != S_IDLE);
            r_tx_done  <= (w_next == S_STOP) && w_tick_pre && (w_bit_next == c_STOP_LAST);
        end
    end

    assign read_req = r_read_req;
    assign tx       = r_tx;
    assign busy     = r_busy;
    assign tx_done  = r_tx_done;

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_reader.sv
// ============================================================================
// tb_fifo_uart_reader : FIFO model + UART frame scoreboard for fifo_uart_reader
// Revision            : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fifo_uart_reader;

    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int DIV      = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * DIV;

    logic       clk            = 1'b0;
    logic       rst            = 1'b1;
    logic       empty_sig      = 1'b1;
    logic [7:0] FIFO_read_data = 8'h00;
    logic       read_req;
    logic       tx;
    logic       busy;
    logic       tx_done;

    fifo_uart_reader #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .BAUD_DIV (DIV)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .empty_sig      (empty_sig),
        .FIFO_read_data (FIFO_read_data),
        .read_req       (read_req),
        .tx             (tx),
        .busy           (busy),
        .tx_done        (tx_done)
    );

    always #5 clk = ~clk;

    int         checks       = 0;
    int         errors       = 0;
    int         cyc          = 0;
    int         last_req_cyc = -1000;
    int         last_end     = 0;
    int         req_count    = 0;
    int         done_count   = 0;
    int         frames_ok    = 0;
    int         total_pushed = 0;
    bit         have_prev    = 1'b0;
    bit         b2b          = 1'b0;
    bit         in_frame     = 1'b0;
    bit         prev_req     = 1'b0;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(b);
        total_pushed++;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (tx_done === 1'b1) done_count++;

    // FIFO read-port model: pop on read_req, data valid the following cycle
    always @(negedge clk) begin
        if (read_req === 1'b1) begin
            check_int("read_req_single_cycle", int'(prev_req), 0);
            check_int("read_req_fifo_nonempty", int'(fifo_q.size() > 0), 1);
            check_int("read_req_outside_reset", int'(rst), 0);
            if (fifo_q.size() > 0) FIFO_read_data = fifo_q.pop_front();
            req_count++;
            last_req_cyc = cyc;
        end
        prev_req = (read_req === 1'b1);
        #1;
        empty_sig = (fifo_q.size() == 0);
    end

    task automatic run_frame();
        logic [11:0] bits;
        logic [7:0]  b;
        int          s, bad_tx, first_bad, bad_done, bad_busy;
        bit          aborted;
        s        = cyc;
        in_frame = 1'b1;
        check_int("req_to_start_latency", s - last_req_cyc, 2);
        if (have_prev) begin
            if (b2b) check_int("b2b_gap", s - last_end, 4);
            else     check_int("min_gap", int'((s - last_end) >= 4), 1);
        end
        check_int("frame_expected", int'(exp_q.size() > 0), 1);
        b = 8'h00;
        if (exp_q.size() > 0) b = exp_q.pop_front();
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = b;
`ifdef UART_TX_PARITY_EN
        bits[9]   = ^b;
`endif
        bad_tx = 0; first_bad = -1; bad_done = 0; bad_busy = 0; aborted = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) begin
                @(negedge clk);
                if (rst) begin
                    aborted = 1'b1;
                    break;
                end
            end
            if (tx !== bits[k / DIV]) begin
                if (first_bad < 0) first_bad = k;
                bad_tx++;
            end
            if (tx_done !== (k == FRAME - 1)) bad_done++;
            if (busy !== 1'b1) bad_busy++;
        end
        if (aborted) begin
            have_prev = 1'b0;
            in_frame  = 1'b0;
            return;
        end
        check_int($sformatf("frame_%02h_bad_tx_cycles_first_%0d", b, first_bad), bad_tx, 0);
        check_int("tx_done_only_last_cycle", bad_done, 0);
        check_int("busy_through_frame", bad_busy, 0);
        last_end  = cyc;
        have_prev = 1'b1;
        frames_ok++;
        @(negedge clk);
        if (!rst) check_int("busy_low_after_stop", int'(busy !== 1'b0), 0);
        in_frame = 1'b0;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst) have_prev = 1'b0;
            else if (tx === 1'b0) run_frame();
            else check_int("idle_tx_done_low", int'(tx_done !== 1'b0), 0);
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((fifo_q.size() != 0 || exp_q.size() != 0 || in_frame || busy !== 1'b0) && n < budget);
        check_int("drain_within_budget", int'(n < budget), 1);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int          n, rq0, dn0;
        logic [7:0]  b2b_bytes[3];
        b2b_bytes[0] = 8'h01; b2b_bytes[1] = 8'h80; b2b_bytes[2] = 8'hFF;

        // Reset held with data waiting: nothing may move
        repeat (3) @(negedge clk);
        push(8'hA5);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_int("reset_hold_req_tx_busy_done", int'({read_req, tx, busy, tx_done}), 4);
        end
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk); check_int("req_low_first_idle", int'(read_req), 0);
        @(negedge clk); check_int("req_pulse_high", int'(read_req), 1);
        @(negedge clk); check_int("req_pulse_end", int'(read_req), 0);
        wait_idle(300);

        // Back-to-back frames
        have_prev = 1'b0;
        b2b = 1'b1;
        rq0 = req_count; dn0 = done_count;
        @(negedge clk);
        foreach (b2b_bytes[i]) push(b2b_bytes[i]);
        wait_idle(600);
        b2b = 1'b0;
        check_int("b2b_req_count", req_count - rq0, 3);
        check_int("b2b_tx_done_count", done_count - dn0, 3);

        // Empty FIFO
        rq0 = req_count; dn0 = done_count;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            check_int("empty_tx_high", int'(tx), 1);
        end
        check_int("empty_no_req", req_count - rq0, 0);
        check_int("empty_no_tx_done", done_count - dn0, 0);

        // Parity-pattern byte (plain 8N1 frame without the macro)
        @(negedge clk); push(8'h07);
        wait_idle(300);

        // Random bytes with random spacing
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 150)) @(negedge clk);
            @(negedge clk);
            push(8'($urandom));
        end
        wait_idle(16 * (FRAME + 10) + 100);

        // Reset during data bit 3 of 8'h3C
        @(negedge clk); push(8'h3C);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx !== 1'b0 && n < 100);
        check_int("midreset_frame_started", int'(n < 100), 1);
        repeat (45) @(negedge clk);
        @(posedge clk); #2 rst = 1'b1; #1;
        check_int("async_reset_tx_high", int'(tx), 1);
        check_int("async_reset_busy_low", int'(busy), 0);
        rq0 = req_count;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 2) push(8'h5A);
            check_int("midreset_hold_outputs", int'({read_req, tx, busy, tx_done}), 4);
        end
        @(posedge clk); #2 rst = 1'b0;
        wait_idle(300);
        check_int("post_reset_single_req", req_count - rq0, 1);

        check_int("frames_delivered", frames_ok, total_pushed - 1);
        check_int("tx_done_per_frame", done_count, frames_ok);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
